// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port RAM between a data (load/store) port and an
// instruction-fetch port. Grants are combinational; the RAM returns read data
// one cycle after the enable, so each port's response (rvalid/rdata) appears
// one cycle after its grant. Data normally wins, but once it has won
// STARVE_LIMIT consecutive times while fetch was waiting, fetch gets one turn.
// STARVE_LIMIT must fit in CNT_W bits (at most 2^CNT_W-1) and be at least 1.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i   data-port request
//   d_gnt_o, d_rvalid_o, d_rdata_o             data-port grant and response
//   i_req_i/i_addr_i                           fetch-port request
//   i_gnt_o, i_rvalid_o, i_rdata_o             fetch-port grant and response
//   mem_en_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o, mem_rdata_i  RAM side
//   hold_flag_o           fetch requested but not granted (pipeline hold)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,

  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,

  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,

  output logic        hold_flag_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_D = 2'd1,
    RESP_I = 2'd2
  } resp_state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             d_read_q, d_read_d;

  // Arbitration. The reset level gates the grants so nothing reaches the RAM
  // while reset is held, even though requests may already be present.
  always_comb begin
    d_gnt_o = 1'b0;
    i_gnt_o = 1'b0;
    if (rst) begin
      if (d_req_i && (starve_cnt_q < LIMIT)) begin
        d_gnt_o = 1'b1;
      end else if (i_req_i) begin
        i_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end
    end
  end

  assign hold_flag_o = i_req_i & ~i_gnt_o;

  // RAM request mux: all write-side fields stay zero unless data is granted.
  always_comb begin
    mem_en_o    = d_gnt_o | i_gnt_o;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (d_gnt_o) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (i_gnt_o) begin
      mem_addr_o  = i_addr_i;
    end
  end

  // Starvation counter: counts data wins while fetch is waiting, saturating
  // at the limit; any fetch grant or an absent fetch request clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (d_gnt_o && i_req_i) begin
      if (starve_cnt_q < LIMIT) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end else if (i_gnt_o || !i_req_i) begin
      starve_cnt_d = '0;
    end
  end

  // Response FSM next state. d_read remembers whether the data access was a
  // read so that a write acknowledge returns zero data instead of RAM output.
  always_comb begin
    state_d  = IDLE;
    d_read_d = 1'b0;
    if (d_gnt_o) begin
      state_d  = RESP_D;
      d_read_d = ~d_we_i;
    end else if (i_gnt_o) begin
      state_d  = RESP_I;
    end
  end

  // Response outputs, decoded from the current response state.
  always_comb begin
    d_rvalid_o = (state_q == RESP_D);
    i_rvalid_o = (state_q == RESP_I);
    d_rdata_o  = 32'h0;
    i_rdata_o  = 32'h0;
    if ((state_q == RESP_D) && d_read_q) begin
      d_rdata_o = mem_rdata_i;
    end
    if (state_q == RESP_I) begin
      i_rdata_o = mem_rdata_i;
    end
  end

  // State registers; an asynchronous reset discards any response in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      d_read_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      d_read_q     <= d_read_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural RAM drives mem_rdata_i;
// a separate reference memory plus a small arbitration model predict grants,
// RAM-side outputs and responses. Inputs change on the falling edge and the
// DUT is sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req_i, d_we_i, i_req_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i, i_addr_i;
  logic        d_gnt_o, d_rvalid_o, i_gnt_o, i_rvalid_o;
  logic [31:0] d_rdata_o, i_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        hold_flag_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .hold_flag_o(hold_flag_o)
  );

  // Behavioural single-port RAM (read-before-write, 1 KB); garbage on the
  // read bus whenever it is not enabled.
  logic [31:0] ram [0:255];
  logic [31:0] ram_w;
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_i <= ram[mem_addr_o[9:2]];
      if (mem_we_o) begin
        ram_w = ram[mem_addr_o[9:2]];
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        ram[mem_addr_o[9:2]] = ram_w;
      end
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  // Reference model: expected memory contents, number of consecutive data
  // wins over a waiting fetch, and the response owed for the last cycle.
  logic [31:0] ref_mem [0:255];
  int          m_cnt;
  int          m_pend;        // 0 none, 1 data, 2 fetch
  logic        m_pend_read;
  logic [31:0] m_pend_data;

  function automatic void model_grant(input logic dr, input logic ir,
                                      output logic gd, output logic gi);
    gd = 1'b0;
    gi = 1'b0;
    if (rst) begin
      if (dr && m_cnt < STARVE_LIMIT) gd = 1'b1;
      else if (ir)                    gi = 1'b1;
      else if (dr)                    gd = 1'b1;
    end
  endfunction

  task automatic drive(input logic dr, input logic we, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic ir, input logic [31:0] ia);
    d_req_i = dr; d_we_i = we; d_be_i = be; d_addr_i = da; d_wdata_i = wd;
    i_req_i = ir; i_addr_i = ia;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance the model by the access chosen this cycle, then move to the next
  // falling edge.
  task automatic clock_model();
    logic gd, gi;
    logic [31:0] w;
    model_grant(d_req_i, i_req_i, gd, gi);
    if (gd) begin
      m_pend      = 1;
      m_pend_read = !d_we_i;
      m_pend_data = ref_mem[d_addr_i[9:2]];
      if (d_we_i) begin
        w = ref_mem[d_addr_i[9:2]];
        for (int b = 0; b < 4; b++)
          if (d_be_i[b]) w[8*b +: 8] = d_wdata_i[8*b +: 8];
        ref_mem[d_addr_i[9:2]] = w;
      end
      m_cnt = i_req_i ? ((m_cnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_cnt + 1) : 0;
    end else if (gi) begin
      m_pend      = 2;
      m_pend_read = 1'b1;
      m_pend_data = ref_mem[i_addr_i[9:2]];
      m_cnt       = 0;
    end else begin
      m_pend = 0;
      m_cnt  = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_cnt = 0; m_pend = 0;
    drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h1234_5678, 1'b1, 32'h80);
    total++; if ({d_gnt_o, i_gnt_o} !== 2'b00) begin bad++; $display("[TB] FAIL rst_gnt got=%b exp=00", {d_gnt_o, i_gnt_o}); end
    total++; if ({mem_en_o, mem_we_o, mem_be_o} !== 6'h0) begin bad++; $display("[TB] FAIL rst_mem_ctl got=%h exp=0", {mem_en_o, mem_we_o, mem_be_o}); end
    total++; if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin bad++; $display("[TB] FAIL rst_mem_bus got=%h exp=0", {mem_addr_o, mem_wdata_o}); end
    total++; if (hold_flag_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_hold got=%b exp=1", hold_flag_o); end
    total++; if ({d_rvalid_o, i_rvalid_o, d_rdata_o, i_rdata_o} !== 66'h0) begin bad++; $display("[TB] FAIL rst_resp got=%h exp=0", {d_rvalid_o, i_rvalid_o, d_rdata_o, i_rdata_o}); end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    // First cycle out of reset may already be granted.
    drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0);
    total++; if (d_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL first_gnt got=%b exp=1", d_gnt_o); end
    clock_model();
    drive_idle();
    total++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== m_pend_data) begin bad++; $display("[TB] FAIL first_resp got=%b/%h exp=1/%h", d_rvalid_o, d_rdata_o, m_pend_data); end
    clock_model();
  endtask

  task automatic test_fetch_only();
    ram[4] = 32'h0050_0093;
    ref_mem[4] = 32'h0050_0093;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h10);
    total++; if (i_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_gnt got=%b%b exp=01", d_gnt_o, i_gnt_o); end
    total++; if (hold_flag_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_hold got=%b exp=0", hold_flag_o); end
    total++; if (mem_addr_o !== 32'h10 || mem_en_o !== 1'b1 || mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_mem got=%h/%b/%b exp=10/1/0", mem_addr_o, mem_en_o, mem_we_o); end
    clock_model();
    drive_idle();
    total++; if (i_rvalid_o !== 1'b1 || d_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_rvalid got=%b%b exp=01", d_rvalid_o, i_rvalid_o); end
    total++; if (i_rdata_o !== 32'h0050_0093) begin bad++; $display("[TB] FAIL fetch_rdata got=%h exp=00500093", i_rdata_o); end
    clock_model();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0);
    total++; if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt got=%b/%b exp=1/1", d_gnt_o, mem_we_o); end
    total++; if (mem_be_o !== 4'hF || mem_wdata_o !== 32'hDEAD_BEEF || mem_addr_o !== 32'h100) begin bad++; $display("[TB] FAIL wr_bus got=%h/%h/%h exp=f/deadbeef/100", mem_be_o, mem_wdata_o, mem_addr_o); end
    clock_model();
    drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0);
    total++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL wr_ack got=%b/%h exp=1/0", d_rvalid_o, d_rdata_o); end
    total++; if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_gnt got=%b/%b exp=1/0", d_gnt_o, mem_we_o); end
    clock_model();
    drive_idle();
    total++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rd_data got=%b/%h exp=1/deadbeef", d_rvalid_o, d_rdata_o); end
    clock_model();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      exp_i = ((k % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
      drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 32'h30);
      total++; if ({d_gnt_o, i_gnt_o} !== {~exp_i, exp_i}) begin bad++; $display("[TB] FAIL starve_gnt cyc=%0d got=%b%b exp=%b%b", k, d_gnt_o, i_gnt_o, ~exp_i, exp_i); end
      total++; if (hold_flag_o !== ~exp_i) begin bad++; $display("[TB] FAIL starve_hold cyc=%0d got=%b exp=%b", k, hold_flag_o, ~exp_i); end
      clock_model();
    end
    drive_idle();
    clock_model();
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 12; k++) begin
      logic is_d;
      is_d = (k % 2 == 0);
      drive(is_d, 1'b0, 4'h0, 32'($urandom_range(0, 255)) << 2, 32'h0,
            !is_d, 32'($urandom_range(0, 255)) << 2);
      total++; if ({d_gnt_o, i_gnt_o} !== {is_d, !is_d}) begin bad++; $display("[TB] FAIL alt_gnt cyc=%0d got=%b%b exp=%b%b", k, d_gnt_o, i_gnt_o, is_d, !is_d); end
      if (k > 0) begin
        total++; if ({d_rvalid_o, i_rvalid_o} !== {m_pend == 1, m_pend == 2}) begin bad++; $display("[TB] FAIL alt_rvalid cyc=%0d got=%b%b exp=%b%b", k, d_rvalid_o, i_rvalid_o, m_pend == 1, m_pend == 2); end
        total++; if ((m_pend == 1 ? d_rdata_o : i_rdata_o) !== m_pend_data) begin bad++; $display("[TB] FAIL alt_rdata cyc=%0d got=%h exp=%h", k, m_pend == 1 ? d_rdata_o : i_rdata_o, m_pend_data); end
      end
      clock_model();
    end
    drive_idle();
    clock_model();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b1, 32'h48);
      clock_model();
    end
    // A data grant was just taken; pull reset before its response is seen.
    rst = 1'b0;
    #1;
    total++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_rvalid got=%b/%h exp=0/0", d_rvalid_o, d_rdata_o); end
    total++; if (d_gnt_o !== 1'b0 || hold_flag_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_gnt got=%b/%b exp=0/1", d_gnt_o, hold_flag_o); end
    m_cnt = 0; m_pend = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < STARVE_LIMIT + 1; k++) begin
      logic exp_i;
      exp_i = (k == STARVE_LIMIT);
      drive(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b1, 32'h48);
      if (k == 0) begin
        total++; if ({d_rvalid_o, i_rvalid_o} !== 2'b00) begin bad++; $display("[TB] FAIL post_rst_rvalid got=%b%b exp=00", d_rvalid_o, i_rvalid_o); end
      end
      total++; if ({d_gnt_o, i_gnt_o} !== {~exp_i, exp_i}) begin bad++; $display("[TB] FAIL post_rst_gnt cyc=%0d got=%b%b exp=%b%b", k, d_gnt_o, i_gnt_o, ~exp_i, exp_i); end
      clock_model();
    end
    drive_idle();
    clock_model();
  endtask

  task automatic test_random();
    logic d_wait, i_wait, gd, gi;
    logic dr, we, ir;
    logic [3:0] be;
    logic [31:0] da, wd, ia, exp_addr, exp_rd_d, exp_rd_i;
    d_wait = 1'b0; i_wait = 1'b0;
    dr = 1'b0; we = 1'b0; ir = 1'b0; be = 4'h0; da = 32'h0; wd = 32'h0; ia = 32'h0;
    for (int k = 0; k < 400; k++) begin
      // Requesters keep their request stable until it is granted.
      if (!d_wait) begin
        dr = ($urandom_range(0, 99) < 65);
        we = $urandom_range(0, 1) == 1;
        be = 4'($urandom);
        da = 32'($urandom_range(0, 255)) << 2;
        wd = $urandom;
      end
      if (!i_wait) begin
        ir = ($urandom_range(0, 99) < 60);
        ia = 32'($urandom_range(0, 255)) << 2;
      end
      drive(dr, we, be, da, wd, ir, ia);
      model_grant(dr, ir, gd, gi);
      exp_addr = gd ? da : (gi ? ia : 32'h0);
      exp_rd_d = (m_pend == 1 && m_pend_read) ? m_pend_data : 32'h0;
      exp_rd_i = (m_pend == 2) ? m_pend_data : 32'h0;
      total++; if ({d_gnt_o, i_gnt_o} !== {gd, gi}) begin bad++; $display("[TB] FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", k, d_gnt_o, i_gnt_o, gd, gi); end
      total++; if (mem_en_o !== (gd | gi) || mem_addr_o !== exp_addr) begin bad++; $display("[TB] FAIL rnd_mem_addr cyc=%0d got=%b/%h exp=%b/%h", k, mem_en_o, mem_addr_o, gd | gi, exp_addr); end
      total++; if ({mem_we_o, mem_be_o, mem_wdata_o} !== (gd ? {we, be, wd} : 37'h0)) begin bad++; $display("[TB] FAIL rnd_mem_wr cyc=%0d got=%h exp=%h", k, {mem_we_o, mem_be_o, mem_wdata_o}, gd ? {we, be, wd} : 37'h0); end
      total++; if (hold_flag_o !== (ir & ~gi)) begin bad++; $display("[TB] FAIL rnd_hold cyc=%0d got=%b exp=%b", k, hold_flag_o, ir & ~gi); end
      total++; if ({d_rvalid_o, i_rvalid_o} !== {m_pend == 1, m_pend == 2}) begin bad++; $display("[TB] FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", k, d_rvalid_o, i_rvalid_o, m_pend == 1, m_pend == 2); end
      total++; if (d_rdata_o !== exp_rd_d || i_rdata_o !== exp_rd_i) begin bad++; $display("[TB] FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", k, d_rdata_o, i_rdata_o, exp_rd_d, exp_rd_i); end
      d_wait = dr & ~gd;
      i_wait = ir & ~gi;
      clock_model();
    end
    drive_idle();
    clock_model();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    rst = 1'b0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
    i_req_i = 1'b0; i_addr_i = 32'h0;
    m_cnt = 0; m_pend = 0; m_pend_read = 1'b0; m_pend_data = 32'h0;
    @(negedge clk);
    test_reset();
    test_fetch_only();
    test_write_read();
    test_starvation();
    test_alternating();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while fetch is waiting.
REQ-002 Parameter CNT_W, default 3: starvation counter width; STARVE_LIMIT SHALL be at most 2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 d_req_i  input  1  data-port (load/store) access request.
REQ-006 d_we_i  input  1  data-port write enable; 0 = read.
REQ-007 d_be_i  input  4  data-port byte enables for writes.
REQ-008 d_addr_i  input  32  data-port byte address.
REQ-009 d_wdata_i  input  32  data-port write data.
REQ-010 d_gnt_o  output  1  data request accepted this cycle.
REQ-011 d_rvalid_o  output  1  data response, one cycle after d_gnt_o.
REQ-012 d_rdata_o  output  32  data read result, valid with d_rvalid_o.
REQ-013 i_req_i  input  1  instruction-fetch read request.
REQ-014 i_addr_i  input  32  fetch byte address.
REQ-015 i_gnt_o  output  1  fetch request accepted this cycle.
REQ-016 i_rvalid_o  output  1  fetch response, one cycle after i_gnt_o.
REQ-017 i_rdata_o  output  32  fetched instruction, valid with i_rvalid_o.
REQ-018 mem_en_o, mem_we_o  output  1 each  single-port RAM enable and write strobe.
REQ-019 mem_be_o  output  4;  mem_addr_o, mem_wdata_o  output  32  RAM byte enables, address, write data.
REQ-020 mem_rdata_i  input  32  RAM read data, valid one cycle after mem_en_o.
REQ-021 hold_flag_o  output  1  fetch stalled; drives pipeline hold to ctrl.

Function
REQ-022 At most one of d_gnt_o and i_gnt_o SHALL be high in any cycle.
REQ-023 Grants are combinational: a requester is granted in the same cycle its request is high and it wins arbitration.
REQ-024 Arbitration: data wins if d_req_i is high and starve_cnt is below STARVE_LIMIT; otherwise fetch wins if i_req_i is high; otherwise data wins if d_req_i is high; otherwise no grant.
REQ-025 starve_cnt update when d granted and i_req_i high: +1, saturating at STARVE_LIMIT.
REQ-026 starve_cnt update when i granted, or i_req_i low: cleared to 0.
REQ-027 mem_en_o SHALL equal d_gnt_o OR i_gnt_o; mem_addr_o SHALL carry the winning requester's address; mem_addr_o SHALL be 0 when idle.
REQ-028 On a data grant, mem_we_o, mem_be_o and mem_wdata_o SHALL take d_we_i, d_be_i and d_wdata_i.
REQ-029 On a fetch grant or idle, mem_we_o, mem_be_o and mem_wdata_o SHALL be 0.
REQ-030 Response FSM states: IDLE, RESP_D, RESP_I; next state is RESP_D on d grant, RESP_I on i grant, else IDLE; evaluated every cycle.
REQ-031 d_rvalid_o = (state==RESP_D); i_rvalid_o = (state==RESP_I); writes also get d_rvalid_o as acknowledge.
REQ-032 d_rdata_o carries mem_rdata_i in RESP_D after a read, else 0.
REQ-033 i_rdata_o carries mem_rdata_i in RESP_I, else 0.
REQ-034 Back-to-back: a new grant is allowed in the response cycle of the previous one; one access per cycle is sustained.
REQ-035 hold_flag_o = i_req_i AND NOT i_gnt_o, combinational.
REQ-036 Requesters hold req/addr/data stable until granted; the arbiter does not register requests.

Reset
REQ-037 While rst is low: state IDLE, starve_cnt 0, d_rvalid_o and i_rvalid_o 0, read-data outputs 0.
REQ-038 While rst is low, all grants and mem_* outputs SHALL be 0 regardless of requests, and hold_flag_o SHALL equal i_req_i.
REQ-039 Reset asserted mid-access SHALL drop any pending response; no rvalid is issued for it after reset releases.
REQ-040 First grant is possible in the first cycle rst is high.

Verification
REQ-041 Only i_req_i, i_addr_i=0x10, RAM[0x10]=0x00500093 -> i_gnt_o same cycle, i_rvalid_o and i_rdata_o=0x00500093 next cycle, hold_flag_o=0.
REQ-042 Data write d_addr_i=0x100, d_wdata_i=0xDEADBEEF, d_be_i=4'hF, then data read of 0x100 -> mem_we_o=1 in first grant cycle, read returns 0xDEADBEEF with d_rvalid_o.
REQ-043 d_req_i and i_req_i held high 10 cycles, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; hold_flag_o high exactly in the D-grant cycles.
REQ-044 Alternating single-cycle requests each cycle -> one grant per cycle; every rvalid goes to the correct port exactly one cycle after its grant.
REQ-045 rst driven low in the cycle after a d grant -> d_rvalid_o stays 0; after release, state is IDLE and starve_cnt is 0.
